// File: rtl/regfile_param_if.sv
// Register file bus: general read/write ports, stack pointer control and
// status register update lines shared by the datapath and the register file.
interface regfile_param_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
);
  logic              wr_en;
  logic [SEL_W-1:0]  wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic [SEL_W-1:0]  rd_a_sel;
  logic [DATA_W-1:0] rd_a_data;
  logic [SEL_W-1:0]  rd_b_sel;
  logic [DATA_W-1:0] rd_b_data;
  logic [1:0]        sp_op;
  logic [DATA_W-1:0] sp_wdata;
  logic [DATA_W-1:0] sp;
  logic [DATA_W+7:0] stack_addr;
  logic              sp_wrap;
  logic              p_load;
  logic [7:0]        p_wdata;
  logic [7:0]        flag_we;
  logic [7:0]        flag_in;
  logic [7:0]        p;

  modport master (
    output wr_en, wr_sel, wr_data, rd_a_sel, rd_b_sel,
           sp_op, sp_wdata, p_load, p_wdata, flag_we, flag_in,
    input  rd_a_data, rd_b_data, sp, stack_addr, sp_wrap, p
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, rd_a_sel, rd_b_sel,
           sp_op, sp_wdata, p_load, p_wdata, flag_we, flag_in,
    output rd_a_data, rd_b_data, sp, stack_addr, sp_wrap, p
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised CPU register file: general registers with two read ports,
// stack pointer with push/pull sequencing, and masked-update status register.
module regfile_param #(
  parameter int                DATA_W     = 8,
  parameter int                NUM_REGS   = 3,
  parameter int                SEL_W      = 2,
  parameter bit                BYPASS     = 1'b1,
  parameter logic [DATA_W-1:0] SP_RESET   = 8'hFD,
  parameter logic [7:0]        P_RESET    = 8'h24,
  parameter logic [7:0]        STACK_PAGE = 8'h01
) (
  input  logic           clk,
  input  logic           reset,
  regfile_param_if.slave bus
);

  localparam logic [1:0] SP_HOLD = 2'b00;
  localparam logic [1:0] SP_PUSH = 2'b01;
  localparam logic [1:0] SP_PULL = 2'b10;
  localparam logic [1:0] SP_LOAD = 2'b11;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] sp_q;
  logic [DATA_W-1:0] sp_next;
  logic [DATA_W-1:0] stack_byte;
  logic              wrap_q;
  logic              wrap_next;
  logic [7:0]        p_q;
  logic              wr_in_range;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  // General register write; out-of-range selects match no register
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (!reset)
        regs[i] <= '0;
      else if (bus.wr_en && bus.wr_sel == SEL_W'(i))
        regs[i] <= bus.wr_data;
    end
  end

  // Read ports: unselected/out-of-range give 0, optional same-cycle bypass
  always_comb begin
    rd_a        = '0;
    rd_b        = '0;
    wr_in_range = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_a_sel == SEL_W'(i)) rd_a = regs[i];
      if (bus.rd_b_sel == SEL_W'(i)) rd_b = regs[i];
      if (bus.wr_sel == SEL_W'(i))   wr_in_range = 1'b1;
    end
    if (BYPASS && bus.wr_en && wr_in_range) begin
      if (bus.wr_sel == bus.rd_a_sel) rd_a = bus.wr_data;
      if (bus.wr_sel == bus.rd_b_sel) rd_b = bus.wr_data;
    end
  end

  // Stack pointer next value, effective stack byte and wrap detection
  always_comb begin
    sp_next    = sp_q;
    stack_byte = sp_q;
    wrap_next  = 1'b0;
    case (bus.sp_op)
      SP_PUSH: begin
        sp_next   = sp_q - DATA_W'(1);
        wrap_next = (sp_q == '0);
      end
      SP_PULL: begin
        sp_next    = sp_q + DATA_W'(1);
        stack_byte = sp_q + DATA_W'(1);
        wrap_next  = (sp_q == '1);
      end
      SP_LOAD: sp_next = bus.sp_wdata;
      SP_HOLD: sp_next = sp_q;
      default: sp_next = sp_q;
    endcase
  end

  // Stack pointer and wrap pulse registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      sp_q   <= SP_RESET;
      wrap_q <= 1'b0;
    end else begin
      sp_q   <= sp_next;
      wrap_q <= wrap_next;
    end
  end

  // Status register: whole load wins over per-flag mask; bit 5 is pinned high
  always_ff @(posedge clk) begin
    if (!reset)
      p_q <= P_RESET | 8'h20;
    else if (bus.p_load)
      p_q <= bus.p_wdata | 8'h20;
    else
      p_q <= (p_q & ~bus.flag_we) | (bus.flag_in & bus.flag_we) | 8'h20;
  end

  assign bus.rd_a_data  = rd_a;
  assign bus.rd_b_data  = rd_b;
  assign bus.sp         = sp_q;
  assign bus.stack_addr = {STACK_PAGE, stack_byte};
  assign bus.sp_wrap    = wrap_q;
  assign bus.p          = p_q;

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the CPU core register file.
- Holds NUM_REGS general registers (index 0 = A, 1 = X, 2 = Y, extras allowed), a stack pointer with push/pull sequencing, and a processor status register with per-flag masked update.
- Provides two independent read ports with optional write bypass, and a stack-address output for the memory interface.
- Sits between the decoder/ALU datapath and the bus unit.

Parameters:
- DATA_W, 8, width of every general register, SP and P.
- NUM_REGS, 3, number of general registers (2..16).
- SEL_W, 2, register select width; ceil(log2(NUM_REGS)), minimum 1.
- BYPASS, 1, 1 = a read of the register being written returns wr_data in the same cycle.
- SP_RESET, 8'hFD, stack pointer value after reset.
- P_RESET, 8'h24, status register value after reset.
- STACK_PAGE, 8'h01, upper byte of stack_addr.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
- wr_en  in  1  general register write strobe
- wr_sel  in  SEL_W  general register write index
- wr_data  in  DATA_W  general register write data
- rd_a_sel  in  SEL_W  read port A index
- rd_a_data  out  DATA_W  read port A data (combinational)
- rd_b_sel  in  SEL_W  read port B index
- rd_b_data  out  DATA_W  read port B data (combinational)
- sp_op  in  2  00 hold, 01 push, 10 pull, 11 load
- sp_wdata  in  DATA_W  SP load value
- sp  out  DATA_W  current stack pointer
- stack_addr  out  DATA_W+8  {STACK_PAGE, effective stack byte}
- sp_wrap  out  1  registered one-cycle pulse on SP wrap-around
- p_load  in  1  load whole P from p_wdata
- p_wdata  in  8  P load value
- flag_we  in  8  per-bit flag update mask
- flag_in  in  8  flag update values
- p  out  8  status register

Behaviour:
- **Reset:** while reset==0 at a clk rising edge, all registers load their reset values. General regs = 0, sp = SP_RESET, p = P_RESET | 8'h20, sp_wrap = 0. Reset overrides every other input in that cycle.
- **General write:** on a clk edge with wr_en=1 and wr_sel < NUM_REGS, reg[wr_sel] <= wr_data. wr_sel >= NUM_REGS is ignored; no register changes.
- **Reads:** combinational.
  - rd_x_sel >= NUM_REGS returns 0.
  - BYPASS=1 and wr_en=1 and wr_sel==rd_x_sel (in range): rd_x_data = wr_data. Otherwise the stored value is returned.
  - Both ports may select the same register.
- **Independence:** general writes, SP ops and P updates are independent. Any combination may occur in the same cycle with no priority between them.
- **SP push (01):** stack_addr = {STACK_PAGE, sp} this cycle; sp <= sp-1 at the edge (post-decrement).
- **SP pull (10):** stack_addr = {STACK_PAGE, sp+1} this cycle; sp <= sp+1 at the edge (pre-increment).
- **SP hold / load:** on hold (00) and load (11), stack_addr = {STACK_PAGE, sp}. Load sets sp <= sp_wdata.
- **SP arithmetic:** modulo 2^DATA_W.
- **sp_wrap:** set to 1 for exactly the cycle after an edge where:
  - a push with sp == 0 occurred, or
  - a pull with sp == all-ones occurred.
  
  Otherwise sp_wrap = 0. A load never asserts sp_wrap.
- **P update:**
  - p_load=1: p <= p_wdata. flag_we is ignored (p_load has priority).
  - p_load=0: for each bit i with flag_we[i]=1, p[i] <= flag_in[i]; other bits hold.
  - Bit 5 always reads 1, regardless of load, flags or reset value.
- **No handshakes:** all updates complete in one cycle; no stall output.

Test Plan:
- Reset with reset=0 for 2 cycles, then release → sp=8'hFD, p=8'h24, rd_a_data=rd_b_data=0 for selects 0..2, sp_wrap=0.
- Write 8'h5A to reg 1 (wr_en=1, wr_sel=1), with rd_a_sel=1 in the same cycle:
  - BYPASS=1: rd_a_data=8'h5A during that cycle.
  - BYPASS=0: rd_a_data=8'h00 until the next cycle.
  - In both cases, reg 1 = 8'h5A afterwards.
- Load sp=8'h01, then push, push → stack_addr 16'h0101 then 16'h0100. sp=8'hFF after the second push; sp_wrap=1 for exactly one cycle after the second push.
- From sp=8'hFF, pull → stack_addr=16'h0100, sp=8'h00, sp_wrap pulses once. A subsequent hold gives stack_addr=16'h0100 and sp_wrap=0.
- p=8'h24, flag_we=8'h82, flag_in=8'h80 → p=8'hA4. Then the same cycle with p_load=1, p_wdata=8'h00 and flag_we=8'hFF → p=8'h20.
- Same cycle: wr_en to reg 0, push and flag update, with reset=0 → all registers take reset values and no write is applied. Also: wr_sel=3 with NUM_REGS=3 → no register changes, and rd_a_sel=3 reads 0.
